// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - word stream between the scan controller and its consumer
//
// Signals:
//   word_data   packed samples, bit k is the k-th sample of the word
//   word_valid  word_data holds a word
//   word_ready  consumer accepts the word when valid and ready are both high
//   word_last   qualifies word_valid, marks the final word of a scan
// Modports: master (controller side), slave (consumer side).
interface mux_scan_ctrl_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;

    modport master (
        output word_data,
        output word_valid,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        input  word_last,
        output word_ready
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sweeps the select of a 512:1 registered tree and packs its output into words
//
// Optional feature macro: MUX_SCAN_ABORT_EN (adds the abort input).
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle scan request, honoured only in IDLE
//   first_sel  first index, sampled with start
//   last_sel   last index (inclusive), sampled with start
//   sel        registered select to the tree
//   mux_out    tree output, valid SAMPLE_LAT cycles after sel
//   word       word stream (master modport of mux_scan_ctrl_if)
//   busy       high while a scan is in progress
//   done       one-cycle pulse after the final word is accepted
//   abort      (MUX_SCAN_ABORT_EN only) discard the scan and return to IDLE
module mux_scan_ctrl #(
    parameter int SEL_W      = 9,
    parameter int WORD_W     = 32,
    parameter int SAMPLE_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [SEL_W-1:0]     first_sel,
    input  logic [SEL_W-1:0]     last_sel,
    output logic [SEL_W-1:0]     sel,
    input  logic                 mux_out,
    mux_scan_ctrl_if.master      word,
    output logic                 busy,
`ifdef MUX_SCAN_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 done
);
    localparam int CW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [SEL_W-1:0]  last_q;
    logic [CW-1:0]     issued_in_word, issued_n;
    logic [CW-1:0]     landed_in_word, landed_n;
    logic [WORD_W-1:0] asm_data, asm_n;
    logic              issue, final_issue, land, kill;
    logic              closed, complete, out_free, xfer, accept_last;

    // Control: which index is issued this cycle and where the FSM goes next.
    always_comb begin
        state_n     = state;
        issue       = 1'b0;
        final_issue = 1'b0;
        accept_last = word.word_valid && word.word_ready && word.word_last;
        case (state)
            IDLE:  if (start) state_n = SCAN;
            SCAN: begin
                issue       = issued_in_word < CW'(WORD_W);
                final_issue = issue && (sel == last_q);
                if (final_issue) state_n = DRAIN;
            end
            DRAIN: if (accept_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
`ifdef MUX_SCAN_ABORT_EN
        kill = abort && (state != IDLE);
`else
        kill = 1'b0;
`endif
        if (kill) state_n = IDLE;
    end

    // Marks which issues have their sample arriving this cycle.
    generate
        if (SAMPLE_LAT == 0) begin : g_lat0
            assign land = issue;
        end else begin : g_latn
            logic [SAMPLE_LAT-1:0] lat_pipe;
            always_ff @(posedge clk) begin
                if (rst || kill) lat_pipe <= '0;
                else             lat_pipe <= (lat_pipe << 1) | SAMPLE_LAT'(issue);
            end
            assign land = lat_pipe[SAMPLE_LAT-1];
        end
    endgenerate

    // Assembly: the arriving sample goes to the next free bit. A word is
    // complete once it is closed (full, or holding the final index) and
    // every sample issued into it has landed; the landing sample counts, so
    // the word can leave on the same edge its last bit arrives.
    always_comb begin
        asm_n    = asm_data;
        issued_n = issued_in_word + CW'(issue);
        landed_n = landed_in_word + CW'(land);
        for (int k = 0; k < WORD_W; k++) begin
            if (land && (landed_in_word == CW'(k))) asm_n[k] = mux_out;
        end
        closed   = (issued_n == CW'(WORD_W)) || (state == DRAIN) || final_issue;
        complete = closed && (issued_n != '0) && (landed_n == issued_n);
        out_free = !word.word_valid || word.word_ready;
        xfer     = complete && out_free;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            sel             <= '0;
            last_q          <= '0;
            issued_in_word  <= '0;
            landed_in_word  <= '0;
            asm_data        <= '0;
            word.word_data  <= '0;
            word.word_valid <= 1'b0;
            word.word_last  <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= accept_last;
            if ((state == IDLE) && start) begin
                sel    <= first_sel;
                last_q <= last_sel;
            end else if (issue) begin
                sel <= sel + SEL_W'(1);
            end
            if (xfer) begin
                word.word_data  <= asm_n;
                word.word_valid <= 1'b1;
                word.word_last  <= (state == DRAIN) || final_issue;
                asm_data        <= '0;
                issued_in_word  <= '0;
                landed_in_word  <= '0;
            end else begin
                asm_data       <= asm_n;
                issued_in_word <= issued_n;
                landed_in_word <= landed_n;
                if (word.word_ready) begin
                    word.word_valid <= 1'b0;
                    word.word_last  <= 1'b0;
                end
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl (SAMPLE_LAT 0 and 2 side by side)
module tb_mux_scan_ctrl;
    localparam int NSEL = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, word_ready, abort;
    logic [8:0] first_sel, last_sel, sel0, sel2;
    logic       mux0, mux2, busy0, busy2, done0, done2;
    logic       pat [NSEL];
    logic       d1, d2;

    mux_scan_ctrl_if #(.WORD_W(32)) w0 ();
    mux_scan_ctrl_if #(.WORD_W(32)) w2 ();
    assign w0.word_ready = word_ready;
    assign w2.word_ready = word_ready;

    assign mux0 = pat[sel0];
    always @(posedge clk) begin
        d1 <= pat[sel2];
        d2 <= d1;
    end
    assign mux2 = d2;

    mux_scan_ctrl #(.SEL_W(9), .WORD_W(32), .SAMPLE_LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .first_sel(first_sel), .last_sel(last_sel),
        .sel(sel0), .mux_out(mux0), .word(w0), .busy(busy0),
`ifdef MUX_SCAN_ABORT_EN
        .abort(abort),
`endif
        .done(done0)
    );

    mux_scan_ctrl #(.SEL_W(9), .WORD_W(32), .SAMPLE_LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .first_sel(first_sel), .last_sel(last_sel),
        .sel(sel2), .mux_out(mux2), .word(w2), .busy(busy2),
`ifdef MUX_SCAN_ABORT_EN
        .abort(abort),
`endif
        .done(done2)
    );

    int          total = 0;
    int          bad = 0;
    bit          armed = 0;
    bit          active [2];
    bit          done_exp [2];
    bit          held [2];
    logic [31:0] held_data [2];
    int          done_cnt [2];
    logic [32:0] expq [2][$];
    logic [32:0] cap [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected words straight from the range rule: N samples, LSB-first, 32 per word.
    task automatic push_exp(input int id, input int f, input int l);
        int n;
        logic [31:0] w;
        n = ((l - f + NSEL) % NSEL) + 1;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w[i % 32] = pat[(f + i) % NSEL];
            if ((i % 32 == 31) || (i == n - 1)) begin
                expq[id].push_back({(i == n - 1) ? 1'b1 : 1'b0, w});
                w = '0;
            end
        end
    endtask

    task automatic mon(input int id, input logic [31:0] wd, input logic wv, input logic wl,
                       input logic bz, input logic dn);
        logic [32:0] e;
        bit was;
        was = active[id];
        chk($sformatf("busy_u%0d", id), 64'(bz), 64'(was));
        chk($sformatf("done_u%0d", id), 64'(dn), 64'(done_exp[id]));
        if (held[id]) begin
            chk($sformatf("hold_valid_u%0d", id), 64'(wv), 64'd1);
            chk($sformatf("hold_data_u%0d", id), 64'(wd), 64'(held_data[id]));
        end
        if (dn === 1'b1) done_cnt[id]++;
        done_exp[id] = 0;
        held[id] = 0;
        if (wv === 1'b1 && word_ready) begin
            if (expq[id].size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_word_u%0d actual=%0h required=none", id, wd);
            end else begin
                e = expq[id].pop_front();
                chk($sformatf("word_data_u%0d", id), 64'(wd), 64'(e[31:0]));
                chk($sformatf("word_last_u%0d", id), 64'(wl), 64'(e[32]));
            end
            if (id == 0) cap.push_back({wl, wd});
            if (wl === 1'b1) begin
                done_exp[id] = 1;
                active[id] = 0;
            end
        end else if (wv === 1'b1) begin
            held[id] = 1;
            held_data[id] = wd;
        end
        if (rst || (abort && was)) begin
            active[id] = 0;
            done_exp[id] = 0;
            held[id] = 0;
            expq[id].delete();
        end else if (!was && start) begin
            active[id] = 1;
            push_exp(id, int'(first_sel), int'(last_sel));
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            mon(0, w0.word_data, w0.word_valid, w0.word_last, busy0, done0);
            mon(1, w2.word_data, w2.word_valid, w2.word_last, busy2, done2);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy0 || busy2) && n < 3000) begin
            step;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 64'd1, 64'd0);
        step;
        chk("q_empty_u0", 64'(expq[0].size()), 64'd0);
        chk("q_empty_u2", 64'(expq[1].size()), 64'd0);
    endtask

    task automatic pulse_start(input int f, input int l);
        cap.delete();
        first_sel = 9'(f);
        last_sel = 9'(l);
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n, dc;
        int wrap_sel [4];
        rst = 1'b1; start = 1'b0; word_ready = 1'b1; abort = 1'b0;
        first_sel = '0; last_sel = '0;
        for (int i = 0; i < NSEL; i++) pat[i] = 1'b0;
        repeat (3) step;
        rst = 1'b0;
        armed = 1;
        chk("rst_sel", 64'(sel0), 64'd0);
        chk("rst_data", 64'(w0.word_data), 64'd0);
        chk("rst_valid", 64'(w0.word_valid), 64'd0);
        chk("rst_last", 64'(w0.word_last), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);

        // Basic scan, with a stray start mid-scan that must be ignored.
        for (int i = 0; i < NSEL; i++) pat[i] = 1'(i & 1);
        dc = done_cnt[0];
        pulse_start(0, 63);
        for (int k = 0; k < 64; k++) begin
            chk("basic_sel", 64'(sel0), 64'(k));
            if (k == 31) chk("first_word_early", 64'(w0.word_valid), 64'd0);
            if (k == 32) chk("first_word_latency", 64'(w0.word_valid), 64'd1);
            if (k == 10) begin start = 1'b1; first_sel = 9'd100; last_sel = 9'd100; end
            if (k == 11) start = 1'b0;
            step;
        end
        wait_idle;
        chk("basic_nwords", 64'(cap.size()), 64'd2);
        if (cap.size() == 2) begin
            chk("basic_w0", 64'(cap[0]), 64'h0AAAAAAAA);
            chk("basic_w1", 64'(cap[1]), 64'h1AAAAAAAA);
        end
        chk("basic_done_cnt", 64'(done_cnt[0] - dc), 64'd1);

        // Partial word.
        for (int i = 0; i < NSEL; i++) pat[i] = 1'b1;
        pulse_start(10, 14);
        wait_idle;
        chk("partial_nwords", 64'(cap.size()), 64'd1);
        if (cap.size() == 1) chk("partial_w", 64'(cap[0]), 64'h10000001F);

        // Wrap-around.
        for (int i = 0; i < NSEL; i++) pat[i] = 1'b0;
        pat[511] = 1'b1;
        pat[0] = 1'b1;
        wrap_sel = '{510, 511, 0, 1};
        pulse_start(510, 1);
        for (int k = 0; k < 4; k++) begin
            chk("wrap_sel", 64'(sel0), 64'(wrap_sel[k]));
            step;
        end
        wait_idle;
        chk("wrap_nwords", 64'(cap.size()), 64'd1);
        if (cap.size() == 1) chk("wrap_w", 64'(cap[0]), 64'h100000006);

        // Backpressure: ready low until 20 cycles after the LAT=2 first word,
        // then a long stall that forces both issue pipelines to hold sel.
        for (int i = 0; i < NSEL; i++) pat[i] = 1'($urandom);
        word_ready = 1'b0;
        pulse_start(0, 127);
        n = 0;
        while (!w2.word_valid && n < 200) begin
            step;
            n++;
        end
        if (n >= 200) chk("bp_first_timeout", 64'd1, 64'd0);
        repeat (20) step;
        word_ready = 1'b1;
        step;
        word_ready = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if (j == 55) begin
                chk("bp_sel_hold_u0", 64'(sel0), 64'd96);
                chk("bp_sel_hold_u2", 64'(sel2), 64'd96);
            end
            step;
        end
        word_ready = 1'b1;
        wait_idle;
        chk("bp_nwords", 64'(cap.size()), 64'd4);

        // Reset mid-scan, then a fresh scan.
        for (int i = 0; i < NSEL; i++) pat[i] = 1'(i & 1);
        pulse_start(0, 63);
        repeat (10) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("midrst_sel_u0", 64'(sel0), 64'd0);
        chk("midrst_sel_u2", 64'(sel2), 64'd0);
        chk("midrst_valid_u0", 64'(w0.word_valid), 64'd0);
        chk("midrst_valid_u2", 64'(w2.word_valid), 64'd0);
        chk("midrst_data_u0", 64'(w0.word_data), 64'd0);
        chk("midrst_busy_u2", 64'(busy2), 64'd0);
        pulse_start(10, 14);
        wait_idle;
        chk("after_rst_nwords", 64'(cap.size()), 64'd1);
        if (cap.size() == 1) chk("after_rst_w", 64'(cap[0]), 64'h10000000A);

`ifdef MUX_SCAN_ABORT_EN
        dc = done_cnt[0];
        pulse_start(0, 63);
        repeat (4) step;
        abort = 1'b1;
        step;
        abort = 1'b0;
        chk("abort_busy_u0", 64'(busy0), 64'd0);
        chk("abort_valid_u0", 64'(w0.word_valid), 64'd0);
        chk("abort_busy_u2", 64'(busy2), 64'd0);
        repeat (10) step;
        chk("abort_no_done", 64'(done_cnt[0] - dc), 64'd0);
        pulse_start(0, 63);
        wait_idle;
        chk("after_abort_nwords", 64'(cap.size()), 64'd2);
        if (cap.size() == 2) chk("after_abort_w1", 64'(cap[1]), 64'h1AAAAAAAA);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
